// File: rtl/counter_write_arbiter_if.sv
// Bundle between the two write clients, the shared counter and the arbiter.
// The master side is the client/counter environment; the slave side is the arbiter.
interface counter_write_arbiter_if #(
  parameter int WIDTH = 9
);
  logic             req1;
  logic             lock1;
  logic             inc1;
  logic [WIDTH-1:0] data1;
  logic             ack1;
  logic             req2;
  logic             lock2;
  logic             inc2;
  logic [WIDTH-1:0] data2;
  logic             ack2;
  logic [WIDTH-1:0] cnt_value;
  logic [WIDTH-1:0] wrdata1;
  logic             wr1;
  logic [WIDTH-1:0] wrdata2;
  logic             wr2;
  logic [1:0]       owner;

  modport master (
    output req1, lock1, inc1, data1, req2, lock2, inc2, data2, cnt_value,
    input  ack1, ack2, wrdata1, wr1, wrdata2, wr2, owner
  );

  modport slave (
    input  req1, lock1, inc1, data1, req2, lock2, inc2, data2, cnt_value,
    output ack1, ack2, wrdata1, wr1, wrdata2, wr2, owner
  );
endinterface

// File: rtl/counter_write_arbiter.sv
// Two-client write arbiter for the shared counter: round-robin grant from IDLE,
// optional locked tenures bounded to MAX_HOLD writes while the other client waits,
// and at most one counter write port enabled in any cycle.
module counter_write_arbiter #(
  parameter int WIDTH    = 9,
  parameter int MAX_HOLD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  counter_write_arbiter_if.slave  bus
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN1 = 2'b01;
  localparam logic [1:0] OWN2 = 2'b10;

  localparam logic PRIO1 = 1'b0;
  localparam logic PRIO2 = 1'b1;

  logic [1:0]        state_r;
  logic [1:0]        state_s;
  logic              prio_r;
  logic              prio_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_s;

  logic              wr1_s;
  logic              wr2_s;
  logic [WIDTH-1:0]  inc_value_s;
  logic              own_req_s;
  logic              own_lock_s;
  logic              other_req_s;
  logic              other_prio_s;

  assign inc_value_s = bus.cnt_value + WIDTH'(1'b1);

  // Write enables and data: only the owning client writes, and reset masks everything.
  always_comb begin
    wr1_s       = 1'b0;
    wr2_s       = 1'b0;
    bus.wrdata1 = {WIDTH{1'b0}};
    bus.wrdata2 = {WIDTH{1'b0}};
    if (rst) begin
      wr1_s = 1'b0;
      wr2_s = 1'b0;
    end else begin
      wr1_s = (state_r == OWN1) && bus.req1;
      wr2_s = (state_r == OWN2) && bus.req2;
    end
    if (wr1_s) begin
      bus.wrdata1 = bus.inc1 ? inc_value_s : bus.data1;
    end else begin
      bus.wrdata1 = {WIDTH{1'b0}};
    end
    if (wr2_s) begin
      bus.wrdata2 = bus.inc2 ? inc_value_s : bus.data2;
    end else begin
      bus.wrdata2 = {WIDTH{1'b0}};
    end
  end

  assign bus.wr1   = wr1_s;
  assign bus.ack1  = wr1_s;
  assign bus.wr2   = wr2_s;
  assign bus.ack2  = wr2_s;
  assign bus.owner = state_r;

  // Select the current owner's controls and the competitor's request.
  always_comb begin
    own_req_s    = 1'b0;
    own_lock_s   = 1'b0;
    other_req_s  = 1'b0;
    other_prio_s = PRIO1;
    if (state_r == OWN2) begin
      own_req_s    = bus.req2;
      own_lock_s   = bus.lock2;
      other_req_s  = bus.req1;
      other_prio_s = PRIO1;
    end else begin
      own_req_s    = bus.req1;
      own_lock_s   = bus.lock1;
      other_req_s  = bus.req2;
      other_prio_s = PRIO2;
    end
  end

  // Next-state arbitration: grant from IDLE, then keep or release the tenure.
  always_comb begin
    state_s    = state_r;
    prio_s     = prio_r;
    hold_cnt_s = hold_cnt_r;
    case (state_r)
      IDLE: begin
        hold_cnt_s = HOLD_ZERO;
        if (bus.req1 && bus.req2) begin
          state_s = (prio_r == PRIO2) ? OWN2 : OWN1;
        end else if (bus.req1) begin
          state_s = OWN1;
        end else if (bus.req2) begin
          state_s = OWN2;
        end else begin
          state_s = IDLE;
        end
      end
      OWN1, OWN2: begin
        if (!own_req_s || !own_lock_s) begin
          // Client released ownership, or finished an unlocked write.
          state_s = IDLE;
          prio_s  = other_prio_s;
        end else if (!other_req_s) begin
          state_s    = state_r;
          hold_cnt_s = (hold_cnt_r == HOLD_LAST) ? hold_cnt_r : hold_cnt_r + HOLD_ONE;
        end else if (hold_cnt_r != HOLD_LAST) begin
          state_s    = state_r;
          hold_cnt_s = hold_cnt_r + HOLD_ONE;
        end else begin
          // Tenure exhausted while the other client waits: forced handoff.
          state_s = IDLE;
          prio_s  = other_prio_s;
        end
      end
      default: begin
        state_s    = IDLE;
        prio_s     = PRIO1;
        hold_cnt_s = HOLD_ZERO;
      end
    endcase
  end

  // State registers with synchronous reset to IDLE, client 1 favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      prio_r     <= PRIO1;
      hold_cnt_r <= HOLD_ZERO;
    end else begin
      state_r    <= state_s;
      prio_r     <= prio_s;
      hold_cnt_r <= hold_cnt_s;
    end
  end

endmodule

// File: tb/tb_counter_write_arbiter.sv
// Self-checking bench for counter_write_arbiter: directed scenarios followed by
// randomized traffic, all compared against a tenure-level reference model.
module tb_counter_write_arbiter;

  localparam int WIDTH    = 9;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic rs;
  logic rq1, lk1, ic1, rq2, lk2, ic2;
  logic [WIDTH-1:0] dt1, dt2, cnt;

  int vectors;
  int miscompares;

  // Reference model: who owns the port, who is favoured next, writes in this tenure.
  int m_own;
  int m_fav;
  int m_n;

  counter_write_arbiter_if #(.WIDTH(WIDTH)) bus ();

  assign bus.req1      = rq1;
  assign bus.lock1     = lk1;
  assign bus.inc1      = ic1;
  assign bus.data1     = dt1;
  assign bus.req2      = rq2;
  assign bus.lock2     = lk2;
  assign bus.inc2      = ic2;
  assign bus.data2     = dt2;
  assign bus.cnt_value = cnt;

  counter_write_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rs),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] wr_value(input logic inc, input logic [WIDTH-1:0] data);
    int v;
    if (inc) v = (int'(cnt) + 1) % (1 << WIDTH);
    else     v = int'(data);
    return WIDTH'(v);
  endfunction

  task automatic drive(input logic r1, input logic l1, input logic i1, input logic [WIDTH-1:0] d1,
                       input logic r2, input logic l2, input logic i2, input logic [WIDTH-1:0] d2);
    rq1 = r1; lk1 = l1; ic1 = i1; dt1 = d1;
    rq2 = r2; lk2 = l2; ic2 = i2; dt2 = d2;
  endtask

  // Let inputs settle, then compare every output with the model's prediction.
  task automatic settle();
    logic e_wr1, e_wr2;
    logic [WIDTH-1:0] e_d1, e_d2;
    logic [1:0] e_own;
    #1;
    e_wr1 = !rs && (m_own == 1) && rq1;
    e_wr2 = !rs && (m_own == 2) && rq2;
    e_d1  = e_wr1 ? wr_value(ic1, dt1) : '0;
    e_d2  = e_wr2 ? wr_value(ic2, dt2) : '0;
    e_own = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
    chk("wr1", 32'(bus.wr1), 32'(e_wr1));
    chk("ack1", 32'(bus.ack1), 32'(e_wr1));
    chk("wrdata1", 32'(bus.wrdata1), 32'(e_d1));
    chk("wr2", 32'(bus.wr2), 32'(e_wr2));
    chk("ack2", 32'(bus.ack2), 32'(e_wr2));
    chk("wrdata2", 32'(bus.wrdata2), 32'(e_d2));
    chk("owner", 32'(bus.owner), 32'(e_own));
  endtask

  // Advance one clock and apply the arbitration rules to the model and counter.
  task automatic tick();
    bit own_req, own_lock, other_req, inc;
    logic [WIDTH-1:0] data;
    bit release_now;
    @(posedge clk);
    #1;
    release_now = 1'b0;
    if (rs) begin
      m_own = 0; m_fav = 1; m_n = 0;
    end else if (m_own == 0) begin
      m_n = 0;
      if (rq1 && rq2) m_own = m_fav;
      else if (rq1)   m_own = 1;
      else if (rq2)   m_own = 2;
    end else begin
      own_req   = (m_own == 1) ? rq1 : rq2;
      own_lock  = (m_own == 1) ? lk1 : lk2;
      other_req = (m_own == 1) ? rq2 : rq1;
      inc       = (m_own == 1) ? ic1 : ic2;
      data      = (m_own == 1) ? dt1 : dt2;
      if (!own_req) begin
        release_now = 1'b1;
      end else begin
        m_n++;
        cnt = wr_value(inc, data);
        if (!own_lock) release_now = 1'b1;
        else if (other_req && m_n >= MAX_HOLD) release_now = 1'b1;
      end
      if (release_now) begin
        m_fav = 3 - m_own;
        m_own = 0;
      end
    end
  endtask

  logic [WIDTH-1:0] wrap_seq [4];

  initial begin
    vectors = 0; miscompares = 0;
    m_own = 0; m_fav = 1; m_n = 0;
    cnt = '0;
    wrap_seq[0] = 9'h1FF; wrap_seq[1] = 9'h000; wrap_seq[2] = 9'h001; wrap_seq[3] = 9'h002;
    drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h000);
    rs = 1'b1;
    @(posedge clk);
    #1;
    rs = 1'b0;
    settle();
    chk("reset_owner", 32'(bus.owner), 32'h0);

    // Single load from client 1.
    drive(1'b1, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0, 9'h000);
    settle(); tick();
    settle();
    chk("load_wr1", 32'(bus.wr1), 32'h1);
    chk("load_data", 32'(bus.wrdata1), 32'h0A5);
    chk("load_owner", 32'(bus.owner), 32'h1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h000);
    settle();
    chk("load_idle", 32'(bus.owner), 32'h0);
    chk("load_cnt_fed", 32'(bus.cnt_value), 32'h0A5);
    tick();

    // Round-robin with simultaneous requests after reset.
    rs = 1'b1; settle(); tick(); rs = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 9'h011, 1'b1, 1'b0, 1'b0, 9'h022);
    settle(); tick();
    settle(); chk("rr_first", 32'(bus.owner), 32'h1); tick();
    drive(1'b0, 1'b0, 1'b0, 9'h011, 1'b1, 1'b0, 1'b0, 9'h022);
    settle(); chk("rr_gap", 32'(bus.owner), 32'h0); tick();
    settle(); chk("rr_second", 32'(bus.wrdata2), 32'h022); tick();
    drive(1'b1, 1'b0, 1'b0, 9'h033, 1'b1, 1'b0, 1'b0, 9'h044);
    settle(); tick();
    settle(); chk("rr_third", 32'(bus.owner), 32'h1); tick();
    drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 9'h044);
    settle(); tick(); settle(); tick();
    drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h000);
    settle(); tick();

    // Locked incrementing tenure across the wrap point.
    cnt = 9'h1FE;
    drive(1'b1, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 9'h000);
    settle(); tick();
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("wrap_data", 32'(bus.wrdata1), 32'(wrap_seq[k]));
      chk("wrap_owner", 32'(bus.owner), 32'h1);
      tick();
    end

    // Client release with lock held, then check that client 2 is now favoured.
    drive(1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 9'h000);
    settle(); chk("rel_nowrite", 32'(bus.wr1), 32'h0); tick();
    settle(); chk("rel_idle", 32'(bus.owner), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 9'h055, 1'b1, 1'b0, 1'b0, 9'h066);
    settle(); tick();
    settle(); chk("rel_prio2", 32'(bus.owner), 32'h2);
    drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h000);
    settle(); tick();
    settle(); tick();

    // Bounded tenure: client 2 arrives during the first write of a locked client 1.
    drive(1'b1, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 9'h133);
    settle(); tick();
    drive(1'b1, 1'b1, 1'b1, 9'h000, 1'b1, 1'b0, 1'b0, 9'h133);
    for (int k = 0; k < MAX_HOLD; k++) begin
      settle(); chk("hold_wr1", 32'(bus.wr1), 32'h1); tick();
    end
    settle();
    chk("hold_gap", 32'(bus.owner), 32'h0);
    chk("hold_gap_wr1", 32'(bus.wr1), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 9'h133);
    tick();
    settle();
    chk("hold_wr2", 32'(bus.wr2), 32'h1);
    chk("hold_data2", 32'(bus.wrdata2), 32'h133);
    tick();
    drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h000);
    settle(); tick();

    // Reset in the middle of a locked client 2 tenure.
    drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 9'h0F0);
    settle(); tick();
    settle(); chk("mid_wr2", 32'(bus.wr2), 32'h1); tick();
    rs = 1'b1;
    settle();
    chk("mid_rst_wr2", 32'(bus.wr2), 32'h0);
    chk("mid_rst_ack2", 32'(bus.ack2), 32'h0);
    tick();
    rs = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 9'h0C3, 1'b1, 1'b0, 1'b0, 9'h03C);
    settle(); chk("mid_owner", 32'(bus.owner), 32'h0); tick();
    settle(); chk("mid_prio1", 32'(bus.owner), 32'h1); tick();
    drive(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h000);
    settle(); tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) cnt = WIDTH'($urandom);
      drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
            WIDTH'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
            WIDTH'($urandom));
      settle();
      vectors++;
      assert ((bus.wr1 & bus.wr2) === 1'b0) else begin
        miscompares++;
        $error("FAIL exclusive observed=%0b%0b expected=not both", bus.wr1, bus.wr2);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_write_arbiter.md
Name: counter_write_arbiter

Overview:
- Upstream stage for the 9-bit shared counter.
- Arbitrates between two client processes so that at most one of the counter's two write ports is enabled in any cycle.
- Each client can load an absolute value or increment the current counter value, and can lock ownership for back-to-back writes.
- Round-robin fairness applies, with a bounded tenure when the other client is waiting.

Parameters:
WIDTH, 9, data width; matches the shared counter value width.
MAX_HOLD, 4, maximum writes per ownership tenure while the other client is requesting (≥1).

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  synchronous reset, active-high.
req1  input  1  client 1 requests a write; held until ack1.
lock1  input  1  client 1 wants to keep ownership after the current write.
inc1  input  1  1: write cnt_value+1; 0: write data1.
data1  input  WIDTH  client 1 load value.
ack1  output  1  client 1 write performed this cycle.
req2, lock2, inc2, data2, ack2  same as above, for client 2.
cnt_value  input  WIDTH  current counter value, fed back from the shared counter.
wrdata1  output  WIDTH  to counter write port 1.
wr1  output  1  to counter write port 1.
wrdata2  output  WIDTH  to counter write port 2.
wr2  output  1  to counter write port 2.
owner  output  2  00 idle, 01 client 1, 10 client 2.

Behaviour:
- States: IDLE, OWN1, OWN2. Registered: state, prio (next favoured client; 0 = client 1), hold_cnt (0..MAX_HOLD-1).
- Reset (rst=1 at an edge): state=IDLE, prio=client 1, hold_cnt=0.
- While rst=1, wr1/wr2/ack1/ack2 are forced 0 combinationally and wrdata1/wrdata2 read 0. This holds even mid-tenure.
- IDLE arbitration:
  - Only req1 → OWN1. Only req2 → OWN2.
  - Both → the client indicated by prio.
  - Neither → stay IDLE.
  - hold_cnt cleared on entry to OWNx.
  - No writes occur in IDLE.
- OWNx with reqx=1:
  - wrx=1, ackx=1 combinationally in that cycle.
  - wrdatax = incx ? (cnt_value+1) mod 2^WIDTH : datax. 0x1FF increments to 0x000 for WIDTH=9.
  - Other port: wr=0, wrdata=0.
  - Counter captures at the next edge. cnt_value is therefore current on the following cycle, so consecutive increments in a locked tenure are exact.
- Write latency: req sampled at edge N in IDLE → write cycle N+1 → counter updated at edge N+2.
- OWNx exit rules, evaluated at the edge ending a write cycle:
  - lockx=0 → IDLE.
  - lockx=1 and other client not requesting → stay; hold_cnt saturates at MAX_HOLD-1.
  - lockx=1, other requesting, hold_cnt<MAX_HOLD-1 → stay; hold_cnt+1.
  - lockx=1, other requesting, hold_cnt==MAX_HOLD-1 → IDLE (forced release).
- OWNx with reqx=0: no write, no ack → IDLE next edge (client release).
- Every transition OWNx→IDLE sets prio to the other client.
- owner reflects the registered state (00 in IDLE and during reset-forced IDLE).
- Invariants:
  - wr1&wr2 never both 1.
  - ackx==wrx.
  - Minimum one IDLE cycle between tenures, including on forced handoff.
- lockx/incx/datax are sampled only when reqx=1 in OWNx; they are ignored otherwise.

Test Plan:
- Reset, then req1=1, inc1=0, data1=0x0A5 at edge 0 → owner=01 at cycle 1, wr1=1, wrdata1=0x0A5, ack1=1, wr2=0; counter reads 0x0A5 after edge 2; owner=00 at cycle 2.
- req1 and req2 both asserted from idle after reset → client 1 served first; client 2 served after one IDLE cycle; a third simultaneous request after that is granted to client 1 (round-robin).
- Client 1 lock1=1, inc1=1, cnt_value starting 0x1FE, client 2 idle, 4 write cycles → wrdata1 sequence 0x1FF, 0x000, 0x001, 0x002 (wrap checked); owner stays 01.
- MAX_HOLD=4, client 1 locked incrementing, req2 raised during client 1's first write → exactly 4 client 1 writes, one IDLE cycle, then client 2 writes data2=0x133 with wr2=1.
- rst asserted in the middle of a client 2 locked tenure → wr2=0 and ack2=0 in the rst cycle; owner=00 next cycle. After release with req1 and req2 high, client 1 wins (prio reset).
- Client 1 owns the port and drops req1 with lock1=1 → no write in that cycle, IDLE next edge, prio=client 2.
